ripple_carry_adder: RTL and testbench
=====================================

Name: ripple_carry_adder

Overview:
- Parameterised N-bit ripple-carry adder computing A + B + Cin as an (N+1)-bit result {Cout, S}.
- Built as an explicit chain of N one-bit full adders; no lookahead.
- Used as the integer add datapath primitive of the RV64 core.
- Provides a combinational result path plus a one-cycle registered copy with flags for pipelined consumers.

Parameters:
- N, 64, operand/sum width in bits; legal range 1..128.

Ports:
- clk  input  1  rising-edge clock; used only by the registered outputs.
- rst  input  1  synchronous, active-high reset.
- A  input  N  operand A, unsigned or two's complement.
- B  input  N  operand B.
- Cin  input  1  carry into bit 0.
- S  output  N  combinational sum bits.
- Cout  output  1  combinational carry out of bit N-1.
- Ovf  output  1  combinational signed overflow: carry into MSB XOR carry out of MSB.
- S_q  output  N  registered S.
- Cout_q  output  1  registered Cout.
- Ovf_q  output  1  registered Ovf.

Behaviour:
- Carry chain: c[0]=Cin.
- For each bit i: S[i]=A[i]^B[i]^c[i] and c[i+1]=(A[i]&B[i])|(c[i]&(A[i]^B[i])).
- Cout=c[N].
- Chain is generated per bit (generate loop of full-adder instances or equivalent per-bit logic). It must not be collapsed into a single '+' operator.
- Required identity for all inputs: {Cout,S} == A + B + Cin, evaluated at N+1 bits.
- Ovf=c[N]^c[N-1]. For N=1, c[N-1] is Cin.
- S, Cout and Ovf are purely combinational. They have no dependency on clk or rst and are valid once the chain settles; worst case is N stage delays.
- Registered outputs update on every rising clk edge: S_q<=S, Cout_q<=Cout, Ovf_q<=Ovf. Latency is 1 cycle and there is no enable or handshake.
- When rst=1 at a rising edge, S_q, Cout_q and Ovf_q become 0. rst has priority over new data.
- Reset mid-operation clears only the registered outputs. The combinational outputs keep tracking the inputs.
- Wrap-around: the sum modulo 2^N appears on S, and the carried-out bit appears on Cout. No saturation.
- X or Z on any input bit may propagate to the affected sum bits and to the carries above it. No masking is performed.

Optional Feature:
- Macro: RIPPLE_CARRY_ADDER_FLAGS_EN.
- When defined, adds these outputs:
  - Z (1 bit, combinational): 1 when S==0.
  - Neg (1 bit, combinational): equals S[N-1].
  - Z_q and Neg_q: registered copies with the same 1-cycle latency; rst clears them to 0.
- When undefined, these ports and their logic do not exist and the rest of the behaviour is unchanged.

Test Plan:
- A=0, B=0, Cin=0 -> S=0, Cout=0, Ovf=0. Next edge: S_q=0. With flags: Z=1.
- A=0x00000000000000FF, B=0x0000000000000001, Cin=0 -> S=0x0000000000000100, Cout=0, Ovf=0. This checks the carry ripple across a byte boundary.
- A=B=0xFFFFFFFFFFFFFFFF, Cin=1 -> S=0xFFFFFFFFFFFFFFFF, Cout=1, Ovf=0, which is the maximum carry case. Next edge: Cout_q=1.
- A=B=0x8000000000000000, Cin=0 -> S=0, Cout=1, Ovf=1, which is MSB overflow. With flags: Z=1, Neg=0.
- Set rst=1 for one edge while A=B=all-ones:
  - at that edge, S_q/Cout_q/Ovf_q go to 0, while S and Cout stay valid combinationally;
  - after rst is released, the next edge reloads the registered outputs.
- 20 random (A, B, Cin) triples with a fixed seed -> after settling, {Cout,S} equals the (N+1)-bit reference sum; one edge later, {Cout_q,S_q} matches.

Source files
------------

// File: rtl/ripple_carry_adder.sv
// N-bit ripple-carry adder: per-bit full-adder chain, combinational {Cout,S,Ovf} plus a registered copy.
// Optional zero/negative flags enabled by defining RIPPLE_CARRY_ADDER_FLAGS_EN.
module ripple_carry_adder #(
    parameter int unsigned N = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] S,
    output logic         Cout,
    output logic         Ovf,
    output logic [N-1:0] S_q,
    output logic         Cout_q,
    output logic         Ovf_q
`ifdef RIPPLE_CARRY_ADDER_FLAGS_EN
    ,
    output logic         Z,
    output logic         Neg,
    output logic         Z_q,
    output logic         Neg_q
`endif
);

    logic [N:0] c;

    assign c[0] = Cin;

    // One full adder per bit; carry ripples strictly from bit 0 upward.
    for (genvar i = 0; i < N; i++) begin : g_fa
        logic p;
        assign p      = A[i] ^ B[i];
        assign S[i]   = p ^ c[i];
        assign c[i+1] = (A[i] & B[i]) | (c[i] & p);
    end

    assign Cout = c[N];
    // For N=1, c[N-1] is c[0], i.e. Cin.
    assign Ovf  = c[N] ^ c[N-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            S_q    <= '0;
            Cout_q <= 1'b0;
            Ovf_q  <= 1'b0;
        end else begin
            S_q    <= S;
            Cout_q <= Cout;
            Ovf_q  <= Ovf;
        end
    end

`ifdef RIPPLE_CARRY_ADDER_FLAGS_EN
    assign Z   = (S == '0);
    assign Neg = S[N-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            Z_q   <= 1'b0;
            Neg_q <= 1'b0;
        end else begin
            Z_q   <= Z;
            Neg_q <= Neg;
        end
    end
`endif

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Randomised self-checking bench for ripple_carry_adder against an arithmetic reference model.
module tb_ripple_carry_adder;

    localparam int unsigned N = 64;
    localparam int unsigned W = N + 1;

    logic         clk;
    logic         rst;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Cin;
    logic [N-1:0] S;
    logic         Cout;
    logic         Ovf;
    logic [N-1:0] S_q;
    logic         Cout_q;
    logic         Ovf_q;
`ifdef RIPPLE_CARRY_ADDER_FLAGS_EN
    logic         Z;
    logic         Neg;
    logic         Z_q;
    logic         Neg_q;
`endif

    int checks = 0;
    int errors = 0;

    ripple_carry_adder #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .A      (A),
        .B      (B),
        .Cin    (Cin),
        .S      (S),
        .Cout   (Cout),
        .Ovf    (Ovf),
        .S_q    (S_q),
        .Cout_q (Cout_q),
        .Ovf_q  (Ovf_q)
`ifdef RIPPLE_CARRY_ADDER_FLAGS_EN
        ,
        .Z      (Z),
        .Neg    (Neg),
        .Z_q    (Z_q),
        .Neg_q  (Neg_q)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: exact arithmetic at N+1 bits; signed overflow from a wider signed sum.
    function automatic logic [W-1:0] ref_sum(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci);
        return W'(a) + W'(b) + W'(ci);
    endfunction

    function automatic logic ref_ovf(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci);
        logic signed [N+1:0] wide;
        logic signed [N+1:0] lo;
        logic signed [N+1:0] hi;
        wide = $signed({{2{a[N-1]}}, a}) + $signed({{2{b[N-1]}}, b}) + $signed((N+2)'(ci));
        lo   = -($signed((N+2)'(1)) <<< (N-1));
        hi   = ($signed((N+2)'(1)) <<< (N-1)) - 1;
        return (wide < lo) || (wide > hi);
    endfunction

    logic [W-1:0] exp_sum;
    logic         exp_ovf;

    // Drive at negedge, check combinational path, then check registered copy after the edge.
    task automatic apply(input string tag, input logic [N-1:0] a, input logic [N-1:0] b, input logic ci);
        @(negedge clk);
        A   = a;
        B   = b;
        Cin = ci;
        exp_sum = ref_sum(a, b, ci);
        exp_ovf = ref_ovf(a, b, ci);
        #1;
        chk({tag, ".sum"}, {Cout, S}, exp_sum);
        chk({tag, ".ovf"}, W'(Ovf), W'(exp_ovf));
`ifdef RIPPLE_CARRY_ADDER_FLAGS_EN
        chk({tag, ".z"}, W'(Z), W'(exp_sum[N-1:0] == '0));
        chk({tag, ".neg"}, W'(Neg), W'(exp_sum[N-1]));
`endif
        @(posedge clk);
        #1;
        chk({tag, ".sum_q"}, {Cout_q, S_q}, exp_sum);
        chk({tag, ".ovf_q"}, W'(Ovf_q), W'(exp_ovf));
`ifdef RIPPLE_CARRY_ADDER_FLAGS_EN
        chk({tag, ".z_q"}, W'(Z_q), W'(exp_sum[N-1:0] == '0));
        chk({tag, ".neg_q"}, W'(Neg_q), W'(exp_sum[N-1]));
`endif
    endtask

    initial begin
        logic [N-1:0] ones;
        logic [N-1:0] msb;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic         rc;
        logic [31:0]  seed_dummy;

        ones = '1;
        msb  = N'(1) << (N - 1);

        rst = 1'b1;
        A   = N'(64'h1234_5678_9ABC_DEF0);
        B   = N'(64'h0FED_CBA9_8765_4321);
        Cin = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.sum_q", {Cout_q, S_q}, '0);
        chk("reset.ovf_q", W'(Ovf_q), '0);
        chk("reset.comb_live", {Cout, S}, ref_sum(A, B, Cin));

        @(negedge clk);
        rst = 1'b0;

        apply("zero", '0, '0, 1'b0);
        apply("byte_ripple", N'(64'hFF), N'(64'h1), 1'b0);
        apply("max_carry", ones, ones, 1'b1);
        apply("msb_ovf", msb, msb, 1'b0);
        apply("neg_ovf", msb - N'(1), N'(1), 1'b0);
        apply("max_carry2", ones, ones, 1'b1);

        // Reset for one edge while operands stay all-ones.
        @(negedge clk);
        A   = ones;
        B   = ones;
        Cin = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid.sum_q", {Cout_q, S_q}, '0);
        chk("rst_mid.ovf_q", W'(Ovf_q), '0);
        chk("rst_mid.sum", {Cout, S}, ref_sum(ones, ones, 1'b0));
`ifdef RIPPLE_CARRY_ADDER_FLAGS_EN
        chk("rst_mid.neg_q", W'(Neg_q), '0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_rel.sum_q", {Cout_q, S_q}, ref_sum(ones, ones, 1'b0));
        chk("rst_rel.ovf_q", W'(Ovf_q), W'(ref_ovf(ones, ones, 1'b0)));

        seed_dummy = $urandom(32'd20240611);
        for (int k = 0; k < 20; k++) begin
            ra = N'({$urandom(), $urandom()});
            rb = N'({$urandom(), $urandom()});
            rc = 1'($urandom());
            if (k % 5 == 0) rb = ~ra;
            apply($sformatf("rand%0d", k), ra, rb, rc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
